// File: rtl/shift_reverse_sequencer.sv
// Multi-cycle shift/rotate/reverse engine: one left-shift-by-1 step plus a bit reverser.
// Right-direction ops run as reverse -> left-shift loop -> reverse.
module shift_reverse_sequencer #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      SHIFT = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;
   localparam logic [2:0] OP_REV = 3'd5;

   state_t           state_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [AMT_W-1:0] cnt_reg;
   logic [2:0]       op_reg;
   logic             sign_reg;
   logic             err_reg;

   logic             in_ready_reg;
   logic             out_valid_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic             out_err_reg;
   logic             busy_reg;

   logic [WIDTH-1:0] acc_rev;
   logic             fill;
   logic             is_right;

   // Pure wiring: bit i of the accumulator lands on bit WIDTH-1-i.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
         assign acc_rev[gi] = acc_reg[WIDTH-1-gi];
      end
   endgenerate

   // In the reversed domain a right rotate is a left rotate, so ROR also recirculates the MSB.
   always_comb begin
      fill = 1'b0;
      case (op_reg)
         OP_SRA:         fill = sign_reg;
         OP_ROL, OP_ROR: fill = acc_reg[WIDTH-1];
         default:        fill = 1'b0;
      endcase
   end

   assign is_right = (op_reg == OP_SRL) || (op_reg == OP_SRA) || (op_reg == OP_ROR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         op_reg        <= '0;
         sign_reg      <= 1'b0;
         err_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_err_reg   <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  acc_reg      <= in_data;
                  cnt_reg      <= in_amt;
                  op_reg       <= in_op;
                  sign_reg     <= in_data[WIDTH-1];
                  err_reg      <= (in_op > OP_REV);
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  case (in_op)
                     OP_SLL, OP_ROL:                 state_reg <= SHIFT;
                     OP_SRL, OP_SRA, OP_ROR, OP_REV: state_reg <= PRE;
                     default:                        state_reg <= DONE;
                  endcase
               end
            end
            PRE: begin
               acc_reg   <= acc_rev;
               state_reg <= (op_reg == OP_REV) ? DONE : SHIFT;
            end
            SHIFT: begin
               if (cnt_reg == '0) begin
                  state_reg <= is_right ? POST : DONE;
               end else begin
                  acc_reg <= {acc_reg[WIDTH-2:0], fill};
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            POST: begin
               acc_reg   <= acc_rev;
               state_reg <= DONE;
            end
            DONE: begin
               // First DONE cycle presents the result; it then holds until the consumer takes it.
               if (!out_valid_reg) begin
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= acc_reg;
                  out_err_reg   <= err_reg;
               end else if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  out_data_reg  <= '0;
                  out_err_reg   <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
               out_data_reg  <= '0;
               out_err_reg   <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_err   = out_err_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_shift_reverse_sequencer.sv
// Bench for shift_reverse_sequencer: arithmetic reference model with a per-cycle
// output compare, plus directed commands with hand-computed results and latencies.
module tb_shift_reverse_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_op = 3'd0;
   logic [7:0] in_data = 8'h00;
   logic [2:0] in_amt = 3'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   shift_reverse_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_data(in_data), .in_amt(in_amt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_res(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a);
      logic [15:0] dd;
      logic [7:0]  r;
      dd = {d, d};
      case (op)
         3'd0: r = d << a;
         3'd1: r = d >> a;
         3'd2: r = 8'($signed(d) >>> a);
         3'd3: begin dd = dd << a; r = dd[15:8]; end
         3'd4: begin dd = dd >> a; r = dd[7:0]; end
         3'd5: for (int i = 0; i < 8; i++) r[i] = d[7-i];
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [2:0] a);
      if (op > 3'd5) return 1;
      if (op == 3'd5) return 2;
      if (op == 3'd0 || op == 3'd3) return int'(a) + 2;
      return int'(a) + 4;
   endfunction

   // Reference model: one command in flight, result due a fixed number of cycles after accept.
   int         cyc = 0;
   bit         m_pending = 1'b0;
   int         m_due = 0;
   logic [7:0] m_data = 8'h00;
   logic       m_err = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pending <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (m_pending) begin
            if (cyc >= m_due && out_ready) m_pending <= 1'b0;
         end else if (in_valid) begin
            m_pending <= 1'b1;
            m_due     <= cyc + 1 + model_lat(in_op, in_amt);
            m_data    <= model_res(in_op, in_data, in_amt);
            m_err     <= (in_op > 3'd5);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_pending && cyc >= m_due) begin
            chk("cyc_out_valid", 32'(out_valid), 32'd1);
            chk("cyc_out_data", 32'(out_data), 32'(m_data));
            chk("cyc_out_err", 32'(out_err), 32'(m_err));
         end else begin
            chk("cyc_out_valid", 32'(out_valid), 32'd0);
            chk("cyc_out_data", 32'(out_data), 32'd0);
            chk("cyc_out_err", 32'(out_err), 32'd0);
         end
         chk("cyc_in_ready", 32'(in_ready), 32'(!m_pending));
         chk("cyc_busy", 32'(busy), 32'(m_pending));
      end
   end

   task automatic run_cmd(input string name, input logic [2:0] op, input logic [7:0] d,
                          input logic [2:0] a, input logic [7:0] exp_d, input logic exp_e,
                          input int exp_lat);
      int lat;
      bit got;
      chk({"model_", name}, 32'(model_res(op, d, a)), 32'(exp_d));
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = op; in_data = d; in_amt = a; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
         else lat++;
      end
      chk({name, "_done"}, 32'(got), 32'd1);
      chk({name, "_data"}, 32'(out_data), 32'(exp_d));
      chk({name, "_err"}, 32'(out_err), 32'(exp_e));
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      $display("txn %s op=%0d data=%02h amt=%0d -> out=%02h err=%0d lat=%0d",
               name, op, d, a, out_data, out_err, lat);
      @(posedge clk);
   endtask

   initial begin
      int n;
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      run_cmd("sll_b4_3", 3'd0, 8'hB4, 3'd3, 8'hA0, 1'b0, 5);
      run_cmd("sra_b4_2", 3'd2, 8'hB4, 3'd2, 8'hED, 1'b0, 6);
      run_cmd("srl_b4_7", 3'd1, 8'hB4, 3'd7, 8'h01, 1'b0, 11);
      run_cmd("srl_80_0", 3'd1, 8'h80, 3'd0, 8'h80, 1'b0, 4);
      run_cmd("rol_81_1", 3'd3, 8'h81, 3'd1, 8'h03, 1'b0, 3);
      run_cmd("ror_81_1", 3'd4, 8'h81, 3'd1, 8'hC0, 1'b0, 5);
      run_cmd("rev_b4", 3'd5, 8'hB4, 3'd6, 8'h2D, 1'b0, 2);
      run_cmd("ill_5a", 3'd6, 8'h5A, 3'd3, 8'h5A, 1'b1, 1);
      run_cmd("sll_after_ill", 3'd0, 8'h0F, 3'd7, 8'h80, 1'b0, 9);
      run_cmd("rol_a5_0", 3'd3, 8'hA5, 3'd0, 8'hA5, 1'b0, 2);
      run_cmd("ror_96_7", 3'd4, 8'h96, 3'd7, 8'h2D, 1'b0, 11);

      // Backpressure: result held, busy-time commands ignored.
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 3'd5; in_data = 8'hB4; in_amt = 3'd0; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_reached_done", 32'(out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = ~in_valid; in_op = 3'd0; in_data = 8'hFF; in_amt = 3'd1;
         chk("bp_hold_data", 32'(out_data), 32'h2D);
         chk("bp_hold_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      $display("txn backpressure rev b4 held 10 cycles out=%02h", out_data);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_released_valid", 32'(out_valid), 32'd0);
      chk("bp_released_ready", 32'(in_ready), 32'd1);

      // Reset in the middle of a shift loop.
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 3'd0; in_data = 8'hFF; in_amt = 3'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_data", 32'(out_data), 32'd0);
      $display("txn reset abort of sll ff amt 7");
      @(posedge clk); #1 rst_n = 1'b1;
      n = 0;
      repeat (15) begin @(negedge clk); if (out_valid) n++; end
      chk("abort_no_result", 32'(n), 32'd0);
      run_cmd("sll_01_1", 3'd0, 8'h01, 3'd1, 8'h02, 1'b0, 3);

      repeat (3) @(posedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
